// File: rtl/axi_pkg.sv
// Shared AXI constants and helpers for the instruction-side SRAM-like to AXI bridge.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam int         AXI_SIZE_W      = 3;
    localparam int         AXI_ID_W        = 4;
    localparam int         MAX_OUT_DEFAULT = 4;
    localparam int         CNT_W           = 3;

    // The SRAM-like size is log2(bytes) in 2 bits; AXI carries it in 3.
    function automatic logic [AXI_SIZE_W-1:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/axi_req_slot.sv
// Single-entry valid/ready holding register for one AXI request channel.
module axi_req_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data
);

    // A load in the handshake cycle replaces the departing entry, so the
    // channel can carry one transfer per cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/inst_sram_axi_bridge.sv
// Instruction-port bridge: SRAM-like req/addr_ok/data_ok to single-beat AXI4,
// in-order completion, bounded read depth, writes only from a fully idle bridge.
module inst_sram_axi_bridge
    import axi_pkg::*;
#(
    parameter logic [AXI_ID_W-1:0] ID      = 4'd0,
    parameter int                  MAX_OUT = MAX_OUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req,
    input  logic                  wr,
    input  logic [1:0]            size,
    input  logic [31:0]           addr,
    input  logic [3:0]            wstrb,
    input  logic [31:0]           wdata,
    output logic                  addr_ok,
    output logic                  data_ok,
    output logic [31:0]           rdata,
    output logic [AXI_ID_W-1:0]   arid,
    output logic [31:0]           araddr,
    output logic [AXI_SIZE_W-1:0] arsize,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [31:0]           rdata_axi,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [AXI_ID_W-1:0]   awid,
    output logic [31:0]           awaddr,
    output logic [AXI_SIZE_W-1:0] awsize,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [31:0]           wdata_axi,
    output logic [3:0]            wstrb_axi,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic                  bvalid,
    output logic                  bready
);

    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_live;
    logic                     wr_busy;
    logic                     wr_busy_live;
    logic                     rst_done;
    logic                     rd_accept;
    logic                     wr_accept;
    logic [31+AXI_SIZE_W:0]   ar_data;
    logic [31+AXI_SIZE_W:0]   aw_data;
    logic [35:0]              w_data;

    // Occupancy as seen after this cycle's data_ok retires, so a full or
    // write-blocked bridge can accept again in the very cycle it completes.
    assign cnt_live     = cnt - CNT_W'(data_ok);
    assign wr_busy_live = wr_busy & ~data_ok;

    assign rd_accept = rst_done & req & ~wr & ~wr_busy_live
                     & (cnt_live < CNT_W'(MAX_OUT)) & (~arvalid | arready);
    assign wr_accept = rst_done & req & wr & (cnt_live == '0) & ~awvalid & ~wvalid;
    assign addr_ok   = rd_accept | wr_accept;

    assign rready = rst_done;
    assign bready = rst_done;
    assign arid   = rst_done ? ID : '0;
    assign awid   = rst_done ? ID : '0;

    axi_req_slot #(.W(32 + AXI_SIZE_W)) u_ar (
        .clk       (clk),
        .resetn    (resetn),
        .load      (rd_accept),
        .load_data ({addr, axi_size(size)}),
        .ready     (arready),
        .valid     (arvalid),
        .data      (ar_data)
    );

    axi_req_slot #(.W(32 + AXI_SIZE_W)) u_aw (
        .clk       (clk),
        .resetn    (resetn),
        .load      (wr_accept),
        .load_data ({addr, axi_size(size)}),
        .ready     (awready),
        .valid     (awvalid),
        .data      (aw_data)
    );

    axi_req_slot #(.W(36)) u_w (
        .clk       (clk),
        .resetn    (resetn),
        .load      (wr_accept),
        .load_data ({wdata, wstrb}),
        .ready     (wready),
        .valid     (wvalid),
        .data      (w_data)
    );

    assign {araddr, arsize}       = ar_data;
    assign {awaddr, awsize}       = aw_data;
    assign {wdata_axi, wstrb_axi} = w_data;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_done <= 1'b0;
            cnt      <= '0;
            wr_busy  <= 1'b0;
            data_ok  <= 1'b0;
            rdata    <= '0;
        end else begin
            rst_done <= 1'b1;
            data_ok  <= (rvalid & rready) | (bvalid & bready);
            if (rvalid & rready)
                rdata <= rdata_axi;
            cnt <= cnt + CNT_W'(addr_ok) - CNT_W'(data_ok);
            // A write is always the only outstanding request, so any data_ok
            // while busy is its completion.
            if (wr_accept)
                wr_busy <= 1'b1;
            else if (data_ok)
                wr_busy <= 1'b0;
        end
    end

endmodule
